// File: rtl/mio_pkg.sv
// Shared definitions for the memory-mapped I/O responder: address map, FSM state
// type and wait-state counter width.
package mio_pkg;

  localparam logic [31:0] RamBase     = 32'h0000_0000;
  localparam logic [31:0] GpioOutAddr = 32'hE000_0000;
  localparam logic [31:0] GpioInAddr  = 32'hE000_0004;
  localparam logic [31:0] TimerAddr   = 32'hF000_0000;

  localparam int unsigned WaitCntW = 4;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } mio_state_e;

  // Source of the registered read data presented during the response cycle.
  typedef enum logic [1:0] {
    SelNone,
    SelRam,
    SelReg
  } mio_rsel_e;

endpackage

// File: rtl/mio_ram.sv
// Single-port synchronous RAM, Words x 32, registered read port. Contents are not reset.
module mio_ram #(
  parameter int unsigned Words = 1024,
  localparam int unsigned Aw   = $clog2(Words)
) (
  input  logic          clock,
  input  logic          en,
  input  logic          we,
  input  logic [Aw-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [Words];
  logic [31:0] rdata_q;

  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (en) begin
      rdata_q <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mio_responder.sv
// Memory-mapped I/O responder: RAM, GPIO and an optional free-running TIMER behind a
// request/ready handshake with WAIT_STATES wait cycles. Define MIO_TIMER_EN to build the timer.
module mio_responder
  import mio_pkg::*;
#(
  parameter int unsigned RAM_WORDS   = 1024,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_req,
  input  logic        mem_w,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        MIO_ready,
  output logic        bus_err,
  input  logic [31:0] gpio_in,
  output logic [31:0] gpio_out
);

  localparam int unsigned RamAw = $clog2(RAM_WORDS);
  localparam logic [WaitCntW-1:0] WsInit = WaitCntW'(WAIT_STATES);

  mio_state_e          state_q, state_d;
  logic [WaitCntW-1:0] cnt_q, cnt_d;
  logic [31:2]         addr_q;
  logic                w_q;
  logic [31:0]         wdata_q;
  logic [31:0]         gpio_out_q;
  mio_rsel_e           sel_q, sel_d;
  logic [31:0]         reg_rdata_q, reg_rdata_d;
  logic                err_q;
  logic [31:0]         ram_rdata;

  // With zero wait states the access commits on the capture edge, so use the live inputs.
  logic [31:2] acc_addr;
  logic        acc_w;
  logic [31:0] acc_wdata;
  assign acc_addr  = (state_q == StIdle) ? addr[31:2] : addr_q;
  assign acc_w     = (state_q == StIdle) ? mem_w      : w_q;
  assign acc_wdata = (state_q == StIdle) ? wdata      : wdata_q;

  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (mem_req) begin
          if (WAIT_STATES == 0) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
            cnt_d   = WsInit;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= WaitCntW'(1)) begin
          state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // The edge entering RESP is the single commit point for every access.
  logic commit;
  assign commit = reset && (state_d == StResp);

  logic hit_ram, hit_gout, hit_gin, hit_tmr, mapped;
  assign hit_ram  = (acc_addr[31:RamAw+2] == '0);
  assign hit_gout = (acc_addr == GpioOutAddr[31:2]);
  assign hit_gin  = (acc_addr == GpioInAddr[31:2]);
  assign mapped   = hit_ram || hit_gout || hit_gin || hit_tmr;

`ifdef MIO_TIMER_EN
  logic [31:0] timer_q;
  assign hit_tmr = (acc_addr == TimerAddr[31:2]);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      timer_q <= '0;
    end else if (commit && acc_w && hit_tmr) begin
      timer_q <= acc_wdata;
    end else begin
      timer_q <= timer_q + 32'd1;
    end
  end
`else
  assign hit_tmr = 1'b0;
`endif

  always_comb begin
    reg_rdata_d = '0;
    if (hit_gout) begin
      reg_rdata_d = gpio_out_q;
    end else if (hit_gin) begin
      reg_rdata_d = gpio_in;
`ifdef MIO_TIMER_EN
    end else if (hit_tmr) begin
      reg_rdata_d = timer_q;
`endif
    end
    sel_d = SelNone;
    if (commit && !acc_w) begin
      if (hit_ram) begin
        sel_d = SelRam;
      end else if (mapped) begin
        sel_d = SelReg;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      addr_q      <= '0;
      w_q         <= 1'b0;
      wdata_q     <= '0;
      gpio_out_q  <= '0;
      sel_q       <= SelNone;
      reg_rdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == StIdle && mem_req) begin
        addr_q  <= addr[31:2];
        w_q     <= mem_w;
        wdata_q <= wdata;
      end
      if (commit && acc_w && hit_gout) begin
        gpio_out_q <= acc_wdata;
      end
      sel_q       <= sel_d;
      reg_rdata_q <= commit ? reg_rdata_d : '0;
      err_q       <= commit && !mapped;
    end
  end

  mio_ram #(
    .Words(RAM_WORDS)
  ) u_ram (
    .clock(clock),
    .en   (commit && hit_ram && !acc_w),
    .we   (commit && hit_ram && acc_w),
    .addr (acc_addr[RamAw+1:2]),
    .wdata(acc_wdata),
    .rdata(ram_rdata)
  );

  always_comb begin
    rdata = '0;
    case (sel_q)
      SelRam:  rdata = ram_rdata;
      SelReg:  rdata = reg_rdata_q;
      default: rdata = '0;
    endcase
  end

  assign MIO_ready = (state_q == StResp);
  assign bus_err   = err_q;
  assign gpio_out  = gpio_out_q;

endmodule
